pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Parametrised program-counter unit for the fetch stage of the 5-stage pipeline. It replaces the plain load/hold PC register with on-chip sequential increment, a prioritised next-PC select, a halt/resume state machine, and a small return-address stack (RAS). Fetch reads `pc_out` as the instruction address. The decode and execute stages drive the redirect, call, return, trap and halt controls.

Parameters:
- `WIDTH`, 16: PC and address width in bits.
- `STEP`, 1: sequential increment per fetch (1 = word-addressed memory).
- `RESET_VECTOR`, 16'h0000: PC value after reset.
- `TRAP_VECTOR`, 16'h0004: PC loaded on a trap or on RAS underflow.
- `RAS_DEPTH`, 4: return-address stack entries; must be ≥ 2.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pcWrite`  in  1  0 = stall, PC holds; 1 = PC may advance.
- `halt`  in  1  halt request from decode.
- `resume`  in  1  leave the HALTED state.
- `redirect_valid`  in  1  load `redirect_target` (branch taken or jump).
- `redirect_target`  in  WIDTH  redirect destination.
- `call`  in  1  qualifies `redirect_valid`: also push the return address.
- `ret`  in  1  pop the RAS and jump to the popped address.
- `trap`  in  1  jump to `TRAP_VECTOR`.
- `pc_out`  out  WIDTH  current fetch address (registered).
- `pc_plus_step`  out  WIDTH  `pc_out + STEP`, combinational, modulo 2^WIDTH.
- `halted`  out  1  1 while in the HALTED state.
- `ras_count`  out  clog2(RAS_DEPTH+1)  number of valid RAS entries.
- `ras_underflow`  out  1  one-cycle pulse when `ret` is taken with an empty RAS.

Behaviour:
- Reset (synchronous, `reset` = 1 at the edge):
  - `pc_out` = `RESET_VECTOR`, state = RUN, `ras_count` = 0, `halted` = 0, `ras_underflow` = 0.
  - Reset overrides every other input, including mid-halt and mid-stall.
- States: RUN and HALTED. `halted` is a registered output equal to (state == HALTED).
- Next-PC priority in RUN, evaluated each edge, highest first:
  1. `trap`: PC ← `TRAP_VECTOR`; RAS untouched; taken even if `pcWrite` = 0.
  2. `redirect_valid` with `pcWrite` = 1: PC ← `redirect_target`. If `call` = 1, also push `pc_plus_step`.
  3. `ret` with `pcWrite` = 1:
     - RAS non-empty: PC ← top entry; pop.
     - RAS empty: PC ← `TRAP_VECTOR`; pulse `ras_underflow` for one cycle.
  4. `halt`: state → HALTED; PC holds. A halt is accepted regardless of `pcWrite`.
  5. `pcWrite` = 0: PC holds; RAS holds.
  6. Otherwise: PC ← `pc_plus_step`.
- Redirect beats halt in the same cycle: the redirect is taken and the halt is ignored; decode must re-assert it.
- `call` without `redirect_valid` has no effect. `ret` together with `redirect_valid` is resolved as redirect; the RAS is not popped.
- HALTED state:
  - PC and RAS hold; `halt`, `redirect_valid`, `ret` and `pcWrite` are ignored.
  - `trap`: PC ← `TRAP_VECTOR`, state → RUN.
  - Else `resume`: state → RUN, PC unchanged; the first increment happens on the following edge.
  - `resume` in RUN is ignored.
- RAS semantics:
  - Circular LIFO.
  - Push when full overwrites the oldest entry; `ras_count` stays at `RAS_DEPTH`.
  - Push and pop never occur in the same cycle, because of the priority order.
- Arithmetic: all PC math is modulo 2^WIDTH, so `pc_out` = all-ones with `STEP` = 1 increments to 0 without error.
- Latency: each decision is visible on `pc_out` one cycle after the edge; there is no combinational path from inputs to `pc_out`.

Decomposition:
- Shared package `pc_pkg`:
  - the state enum (RUN, HALTED);
  - next-PC select encoding (SEL_TRAP, SEL_REDIR, SEL_RET, SEL_HOLD, SEL_INC);
  - default `RESET_VECTOR` and `TRAP_VECTOR` constants.
- One sub-module, `return_addr_stack`:
  - parameters: `WIDTH`, `DEPTH`;
  - ports: push, pop, push_data, top, count, empty, full;
  - holds the circular overwrite-on-full logic.
- `pc_sequencer` holds the FSM, the priority select and the PC register.

Test Plan:
1. Reset, then `pcWrite` = 1 for 3 cycles → `pc_out` = 0000, 0001, 0002, 0003; assert `reset` mid-run → `pc_out` = 0000 the next cycle.
2. At PC 0010: `redirect_valid` = 1, `call` = 1, target 0040 → PC = 0040, `ras_count` = 1. Then `ret` → PC = 0011, `ras_count` = 0.
3. `ret` with an empty RAS → PC = 0004, `ras_underflow` high for exactly one cycle.
4. Push 5 return addresses with `RAS_DEPTH` = 4 (A1..A5) → `ras_count` = 4. Four `ret`s yield A5, A4, A3, A2; a fifth `ret` underflows to 0004.
5. `halt` at PC 0020 → `halted` = 1, PC stays 0020 for 10 cycles despite `redirect_valid`/`pcWrite`. `resume` → `halted` = 0, PC = 0020, then 0021.
6. `pcWrite` = 0 with `trap` = 1 → PC = 0004. `halt` + `redirect_valid` (target 0030) in the same cycle → PC = 0030, `halted` stays 0. PC = FFFF with increment → PC = 0000.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: FSM states,
// next-PC select encoding and default vectors.
package pc_pkg;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    typedef enum logic [2:0] {
        SEL_TRAP  = 3'd0,
        SEL_REDIR = 3'd1,
        SEL_RET   = 3'd2,
        SEL_HOLD  = 3'd3,
        SEL_INC   = 3'd4
    } pc_sel_e;

    localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;
    localparam logic [15:0] DEF_TRAP_VECTOR  = 16'h0004;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry, so deep call chains lose their outermost return address.
module return_addr_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    top_idx;

    // ptr_q points at the next free slot; the top lives one slot behind it
    assign top_idx = (ptr_q == '0) ? LAST : ptr_q - PW'(1);
    assign top     = mem_q[top_idx];
    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
            if (!full) count_d = count_q + CW'(1);
        end else if (pop && !empty) begin
            ptr_d   = top_idx;
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[ptr_q] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: prioritised next-PC select, run/halt FSM
// and a return-address stack for call/return prediction-free sequencing.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               STEP         = 1,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEF_TRAP_VECTOR),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           pcWrite,
    input  logic                           halt,
    input  logic                           resume,
    input  logic                           redirect_valid,
    input  logic [WIDTH-1:0]               redirect_target,
    input  logic                           call,
    input  logic                           ret,
    input  logic                           trap,
    output logic [WIDTH-1:0]               pc_out,
    output logic [WIDTH-1:0]               pc_plus_step,
    output logic                           halted,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_underflow
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [0:0]       state_q, state_d;
    logic             halted_q;
    logic             underflow_q, underflow_d;
    pc_sel_e          sel;
    logic             ras_push, ras_pop;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty, ras_full;

    assign pc_plus_step  = pc_q + WIDTH'(STEP);
    assign pc_out        = pc_q;
    assign halted        = halted_q;
    assign ras_underflow = underflow_q;

    return_addr_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus_step),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_comb begin
        sel         = SEL_HOLD;
        state_d     = state_q;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        underflow_d = 1'b0;
        if (state_q == ST_RUN) begin
            if (trap) begin
                sel = SEL_TRAP;
            end else if (redirect_valid && pcWrite) begin
                sel      = SEL_REDIR;
                ras_push = call;
            end else if (ret && pcWrite) begin
                // A return with nothing to return to is treated like a trap
                if (ras_empty) begin
                    sel         = SEL_TRAP;
                    underflow_d = 1'b1;
                end else begin
                    sel     = SEL_RET;
                    ras_pop = 1'b1;
                end
            end else if (halt) begin
                state_d = ST_HALTED;
            end else if (pcWrite) begin
                sel = SEL_INC;
            end
        end else begin
            if (trap) begin
                sel     = SEL_TRAP;
                state_d = ST_RUN;
            end else if (resume) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        pc_d = pc_q;
        case (sel)
            SEL_TRAP:  pc_d = TRAP_VECTOR;
            SEL_REDIR: pc_d = redirect_target;
            SEL_RET:   pc_d = ras_top;
            SEL_INC:   pc_d = pc_plus_step;
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            state_q     <= ST_RUN;
            halted_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            halted_q    <= (state_d == ST_HALTED);
            underflow_q <= underflow_d;
        end
    end

    // ras_full is only observed through ras_count at this level
    logic unused_full;
    assign unused_full = ras_full;

endmodule
